// File: rtl/pulp_clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// pulp_clock_gating
//   Latch-based integrated clock-gating cell. The enable is captured while the
//   source clock is low, so the gated clock can only start or stop on a clean
//   rising edge and never glitches mid-pulse.
//   clk_i     : source clock
//   en_i      : functional enable
//   test_en_i : scan/test enable, forces the clock on
//   clk_o     : gated clock
// -----------------------------------------------------------------------------
module pulp_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latch;

  // NOTE: this latch is intentional; it is the glitch filter of the ICG and is
  // transparent only in the low phase of the source clock.
  always_latch begin
    if (!clk_i) en_latch <= en_i | test_en_i;
  end

  assign clk_o = clk_i & en_latch;

endmodule

// -----------------------------------------------------------------------------
// pulp_clock_gate_ctrl
//   Multi-channel automatic clock-gating controller. Each channel watches its
//   domain for a run of consecutive idle cycles; after idle_thr_i such cycles
//   its clock is stopped. Any wake source restarts the clock, and ready_o
//   returns once the clock has run for WAKE_CYCLES settle cycles. Each channel
//   also counts (saturating) the cycles it spent gated.
//
//   clk_i        : ungated source clock, all state runs on it
//   rst_i        : synchronous reset, active-high
//   scan_cg_en_i : forces every clk_o running (state machines unaffected)
//   idle_thr_i   : idle cycles required before gating, 0 disables gating
//   auto_en_i    : per-channel auto-gating enable
//   sw_en_i      : per-channel force-on
//   busy_i       : per-channel activity from the domain
//   wake_req_i   : per-channel explicit wake request (level)
//   clr_stat_i   : clears all gated-cycle counters
//   clk_o        : per-channel gated clocks
//   ready_o      : per-channel clock running and settled
//   gated_o      : per-channel clock stopped
//   gated_cnt_o  : per-channel gated-cycle count, channel c at [c*STAT_W +: STAT_W]
// -----------------------------------------------------------------------------
module pulp_clock_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int THR_W       = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int STAT_W      = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     scan_cg_en_i,
  input  logic [THR_W-1:0]         idle_thr_i,
  input  logic [NUM_CH-1:0]        auto_en_i,
  input  logic [NUM_CH-1:0]        sw_en_i,
  input  logic [NUM_CH-1:0]        busy_i,
  input  logic [NUM_CH-1:0]        wake_req_i,
  input  logic                     clr_stat_i,
  output logic [NUM_CH-1:0]        clk_o,
  output logic [NUM_CH-1:0]        ready_o,
  output logic [NUM_CH-1:0]        gated_o,
  output logic [NUM_CH*STAT_W-1:0] gated_cnt_o
);

  localparam int WCNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_IDLE,
    ST_GATED,
    ST_WAKE
  } state_t;

  // A zero threshold means "never gate", folded into the idle qualifier so a
  // gated channel also wakes when the threshold is cleared.
  logic thr_nz;
  logic thr_one;

  assign thr_nz  = |idle_thr_i;
  assign thr_one = (idle_thr_i == THR_W'(1));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    state_t            state;
    logic [THR_W-1:0]  cnt;
    logic [WCNT_W-1:0] wcnt;
    logic              en;
    logic              ready;
    logic              gated;
    logic [STAT_W-1:0] stat;
    logic              idle;

    assign idle = auto_en_i[c] & ~sw_en_i[c] & ~busy_i[c] & ~wake_req_i[c] & thr_nz;

    // Outputs are registered alongside the state so en never has a
    // combinational path from the inputs to the gating cell.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state <= ST_RUN;
        cnt   <= '0;
        wcnt  <= '0;
        en    <= 1'b1;
        ready <= 1'b1;
        gated <= 1'b0;
      end else begin
        unique case (state)
          ST_RUN: begin
            if (idle) begin
              if (thr_one) begin
                state <= ST_GATED;
                cnt   <= '0;
                en    <= 1'b0;
                ready <= 1'b0;
                gated <= 1'b1;
              end else begin
                state <= ST_IDLE;
                cnt   <= THR_W'(1);
              end
            end
          end

          ST_IDLE: begin
            if (!idle) begin
              state <= ST_RUN;
              cnt   <= '0;
            // >= rather than == so a threshold lowered below the running
            // count still gates on the next idle cycle.
            end else if (({1'b0, cnt} + (THR_W+1)'(1)) >= {1'b0, idle_thr_i}) begin
              state <= ST_GATED;
              cnt   <= '0;
              en    <= 1'b0;
              ready <= 1'b0;
              gated <= 1'b1;
            end else begin
              cnt <= cnt + THR_W'(1);
            end
          end

          ST_GATED: begin
            if (!idle) begin
              state <= ST_WAKE;
              wcnt  <= '0;
              en    <= 1'b1;
              gated <= 1'b0;
            end
          end

          ST_WAKE: begin
            // Settle period: wake sources are ignored and re-gating is not
            // possible until the channel is back in RUN.
            if (wcnt == WCNT_LAST) begin
              state <= ST_RUN;
              wcnt  <= '0;
              ready <= 1'b1;
            end else begin
              wcnt <= wcnt + WCNT_W'(1);
            end
          end

          default: begin
            state <= ST_RUN;
            cnt   <= '0;
            wcnt  <= '0;
            en    <= 1'b1;
            ready <= 1'b1;
            gated <= 1'b0;
          end
        endcase
      end
    end

    // Saturating gated-cycle statistic; clear wins over increment.
    always_ff @(posedge clk_i) begin
      if (rst_i || clr_stat_i) begin
        stat <= '0;
      end else if (gated && (stat != {STAT_W{1'b1}})) begin
        stat <= stat + STAT_W'(1);
      end
    end

    pulp_clock_gating u_cg (
      .clk_i     (clk_i),
      .en_i      (en),
      .test_en_i (scan_cg_en_i),
      .clk_o     (clk_o[c])
    );

    assign ready_o[c]                      = ready;
    assign gated_o[c]                      = gated;
    assign gated_cnt_o[c*STAT_W +: STAT_W] = stat;

  end : g_ch

endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pulp_clock_gate_ctrl
//   Randomised stimulus against a per-channel behavioural model: each channel
//   is described by "gated?", "settle cycles remaining", "current idle streak"
//   and "gated-cycle total". Outputs are compared 1 time unit after every
//   rising edge; clk_o is compared in the high phase against the enable that
//   was in force during the preceding cycle.
// -----------------------------------------------------------------------------
module tb_pulp_clock_gate_ctrl;

  localparam int NUM_CH      = 4;
  localparam int THR_W       = 8;
  localparam int WAKE_CYCLES = 2;
  localparam int STAT_W      = 4;
  localparam int STAT_MAX    = (1 << STAT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     scan_cg_en;
  logic [THR_W-1:0]         idle_thr;
  logic [NUM_CH-1:0]        auto_en;
  logic [NUM_CH-1:0]        sw_en;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        wake_req;
  logic                     clr_stat;
  logic [NUM_CH-1:0]        clk_g;
  logic [NUM_CH-1:0]        ready;
  logic [NUM_CH-1:0]        gated;
  logic [NUM_CH*STAT_W-1:0] gated_cnt;

  always #5 clk = ~clk;

  pulp_clock_gate_ctrl #(
    .NUM_CH      (NUM_CH),
    .THR_W       (THR_W),
    .WAKE_CYCLES (WAKE_CYCLES),
    .STAT_W      (STAT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .scan_cg_en_i (scan_cg_en),
    .idle_thr_i   (idle_thr),
    .auto_en_i    (auto_en),
    .sw_en_i      (sw_en),
    .busy_i       (busy),
    .wake_req_i   (wake_req),
    .clr_stat_i   (clr_stat),
    .clk_o        (clk_g),
    .ready_o      (ready),
    .gated_o      (gated),
    .gated_cnt_o  (gated_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  bit m_gated  [NUM_CH];
  int m_wake   [NUM_CH];
  int m_streak [NUM_CH];
  int m_stat   [NUM_CH];
  bit clk_chk = 1'b0;
  int gated_cycles = 0;

  function automatic logic [NUM_CH-1:0] exp_ready();
    for (int c = 0; c < NUM_CH; c++) exp_ready[c] = !m_gated[c] && (m_wake[c] == 0);
  endfunction

  function automatic logic [NUM_CH-1:0] exp_gated();
    for (int c = 0; c < NUM_CH; c++) exp_gated[c] = m_gated[c];
  endfunction

  function automatic logic [NUM_CH*STAT_W-1:0] exp_cnt();
    for (int c = 0; c < NUM_CH; c++) exp_cnt[c*STAT_W +: STAT_W] = STAT_W'(m_stat[c]);
  endfunction

  // Advance the model by one rising edge using the inputs presently applied.
  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      bit idle;
      idle = auto_en[c] && !sw_en[c] && !busy[c] && !wake_req[c] && (idle_thr != 0);
      if (rst) begin
        m_gated[c]  = 1'b0;
        m_wake[c]   = 0;
        m_streak[c] = 0;
        m_stat[c]   = 0;
      end else begin
        if (clr_stat)                               m_stat[c] = 0;
        else if (m_gated[c] && m_stat[c] < STAT_MAX) m_stat[c]++;

        if (m_gated[c]) begin
          if (!idle) begin
            m_gated[c] = 1'b0;
            m_wake[c]  = WAKE_CYCLES;
          end
        end else if (m_wake[c] > 0) begin
          m_wake[c]--;
        end else if (idle) begin
          if (m_streak[c] + 1 >= int'(idle_thr)) begin
            m_gated[c]  = 1'b1;
            m_streak[c] = 0;
          end else begin
            m_streak[c]++;
          end
        end else begin
          m_streak[c] = 0;
        end
      end
    end
  endtask

  // One clock cycle: inputs were applied in the low phase; evaluate the model
  // at the rising edge and compare just after it.
  task automatic tick();
    logic [NUM_CH-1:0] exp_clk;
    @(posedge clk);
    for (int c = 0; c < NUM_CH; c++) exp_clk[c] = !m_gated[c] || scan_cg_en;
    model_step();
    #1;
    check("ready", 64'(ready), 64'(exp_ready()));
    check("gated", 64'(gated), 64'(exp_gated()));
    check("gated_cnt", 64'(gated_cnt), 64'(exp_cnt()));
    if (clk_chk) check("clk_high", 64'(clk_g), 64'(exp_clk));
    for (int c = 0; c < NUM_CH; c++) if (m_gated[c]) gated_cycles++;
    @(negedge clk);
    #1;
    if (clk_chk) check("clk_low", 64'(clk_g), 64'(0));
    clk_chk = 1'b1;
  endtask

  task automatic rand_inputs();
    busy     = '0;
    wake_req = '0;
    sw_en    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      busy[c]     = ($urandom_range(0, 11) == 0);
      wake_req[c] = ($urandom_range(0, 39) == 0);
      sw_en[c]    = ($urandom_range(0, 49) == 0);
    end
    if ($urandom_range(0, 99) == 0) begin
      auto_en = NUM_CH'($urandom);
      auto_en = auto_en | NUM_CH'($urandom);
    end
    if ($urandom_range(0, 119) == 0) idle_thr = THR_W'($urandom_range(0, 7));
    clr_stat = ($urandom_range(0, 59) == 0);
    if ($urandom_range(0, 79) == 0) scan_cg_en = ~scan_cg_en;
    rst = ($urandom_range(0, 499) == 0);
  endtask

  initial begin
    rst        = 1'b1;
    scan_cg_en = 1'b0;
    idle_thr   = THR_W'(4);
    auto_en    = '1;
    sw_en      = '0;
    busy       = '0;
    wake_req   = '0;
    clr_stat   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_gated[c] = 1'b0; m_wake[c] = 0; m_streak[c] = 0; m_stat[c] = 0;
    end

    // Reset, then plain idle with threshold 4: gating after 4 idle cycles,
    // and the counter saturates in the gated stretch.
    tick();
    tick();
    rst = 1'b0;
    repeat (24) tick();

    // Busy pulse on channel 0 after 3 idle cycles restarts its streak.
    busy = '1;
    tick();
    busy = '0;
    repeat (3) tick();
    busy[0] = 1'b1;
    tick();
    busy[0] = 1'b0;
    repeat (8) tick();

    // Explicit wake on channel 1, then scan forcing while gated.
    wake_req[1] = 1'b1;
    tick();
    wake_req[1] = 1'b0;
    repeat (10) tick();
    scan_cg_en = 1'b1;
    repeat (4) tick();
    scan_cg_en = 1'b0;
    repeat (4) tick();

    // Threshold 0: wakes everything and never gates.
    idle_thr = '0;
    repeat (200) tick();

    // Threshold 1, then clear while gated, then reset while gated.
    idle_thr = THR_W'(1);
    repeat (6) tick();
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();

    // Randomised stretch.
    idle_thr = THR_W'(3);
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      tick();
    end

    if (gated_cycles == 0) begin
      n_err++;
      $display("FAIL coverage: got 0 gated cycles expected nonzero");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
